// File: rtl/lcd_hd44780_framebuf_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lcd_hd44780_framebuf_ctrl
// Purpose  : HD44780 character-LCD driver with an internal frame buffer.
//            The panel is initialised once and then refreshed continuously
//            from the buffer. E timing is generated as SETUP/PULSE/HOLD
//            phases counted in system clocks.
// Ports    : clk, reset (async, active high), ready_i (init start enable),
//            wr_en/wr_addr/wr_data (frame-buffer write port),
//            init_done, frame_done (1-cycle end-of-refresh pulse),
//            lcd_rs, lcd_rw (tied 0), lcd_en, lcd_data[7:0].
// Options  : define LCD_4BIT_EN for a 4-bit bus on lcd_data[7:4].
// Revision : 1.0 - initial release
// ============================================================================
module lcd_hd44780_framebuf_ctrl #(
  parameter int NUM_ROWS          = 2,
  parameter int NUM_COLS          = 16,
  parameter int POWERUP_CYCLES    = 2000000,
  parameter int SETUP_CYCLES      = 4,
  parameter int EN_HIGH_CYCLES    = 25,
  parameter int CMD_HOLD_CYCLES   = 2500,
  parameter int CLEAR_HOLD_CYCLES = 100000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 ready_i,
  input  logic                                 wr_en,
  input  logic [$clog2(NUM_ROWS*NUM_COLS)-1:0] wr_addr,
  input  logic [7:0]                           wr_data,
  output logic                                 init_done,
  output logic                                 frame_done,
  output logic                                 lcd_rs,
  output logic                                 lcd_rw,
  output logic                                 lcd_en,
  output logic [7:0]                           lcd_data
);

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int DEPTH   = NUM_ROWS * NUM_COLS;
  localparam int AW      = $clog2(DEPTH);
  localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int COL_W   = $clog2(NUM_COLS);
  localparam int CNT_MAX = max_of(max_of(POWERUP_CYCLES, CLEAR_HOLD_CYCLES),
                                  max_of(CMD_HOLD_CYCLES, max_of(SETUP_CYCLES, EN_HIGH_CYCLES)));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
`ifdef LCD_4BIT_EN
  localparam int INIT_LEN = 8;
`else
  localparam int INIT_LEN = 4;
`endif
  localparam int IDX_W   = $clog2(INIT_LEN);

  typedef enum logic [2:0] {PWR_WAIT, WAIT_READY, INIT, SET_ROW, WR_CHARS} state_t;
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_PULSE, PH_HOLD} phase_t;

  state_t             state, state_n;
  phase_t             phase;
  logic [CNT_W-1:0]   cnt, hold_len;
  logic [ROW_W-1:0]   row, row_n;
  logic [COL_W-1:0]   col, col_n;
  logic [IDX_W-1:0]   init_idx, idx_n;
  logic [7:0]         fb [DEPTH];
  logic               load, fd_n, id_set, hold_end, byte_done, clear_cmd;
  logic               item_rs, item_single;
  logic [7:0]         item_byte, row_base;
  logic [AW-1:0]      rd_idx;
`ifdef LCD_4BIT_EN
  logic [7:0]         byte_q;
  logic               lo_nib, single, first_half;
`endif

  assign lcd_rw = 1'b0;

  // Hold length depends on the byte in flight; between the two nibbles of a
  // 4-bit transfer the hold is only SETUP_CYCLES long.
  always_comb begin
`ifdef LCD_4BIT_EN
    clear_cmd  = !lcd_rs && (byte_q == 8'h01);
    first_half = !lo_nib && !single;
    hold_len   = first_half ? CNT_W'(SETUP_CYCLES)
               : (clear_cmd ? CNT_W'(CLEAR_HOLD_CYCLES) : CNT_W'(CMD_HOLD_CYCLES));
    hold_end   = (phase == PH_HOLD) && (cnt == hold_len - CNT_W'(1));
    byte_done  = hold_end && !first_half;
`else
    clear_cmd  = !lcd_rs && (lcd_data == 8'h01);
    hold_len   = clear_cmd ? CNT_W'(CLEAR_HOLD_CYCLES) : CNT_W'(CMD_HOLD_CYCLES);
    hold_end   = (phase == PH_HOLD) && (cnt == hold_len - CNT_W'(1));
    byte_done  = hold_end;
`endif
  end

  // Next-state logic. The next byte is chosen from the *next* state so that a
  // new SETUP starts on the cycle right after the previous hold ends.
  always_comb begin
    state_n     = state;
    row_n       = row;
    col_n       = col;
    idx_n       = init_idx;
    load        = 1'b0;
    fd_n        = 1'b0;
    id_set      = 1'b0;
    item_rs     = 1'b0;
    item_single = 1'b0;
    item_byte   = 8'h00;
    row_base    = 8'h00;
    rd_idx      = '0;
    case (state)
      PWR_WAIT:   if (cnt == CNT_W'(POWERUP_CYCLES - 1)) state_n = WAIT_READY;
      WAIT_READY: if (ready_i) begin
        state_n = INIT;
        idx_n   = '0;
        load    = 1'b1;
      end
      INIT: if (byte_done) begin
        load = 1'b1;
        if (init_idx == IDX_W'(INIT_LEN - 1)) begin
          state_n = SET_ROW;
          row_n   = '0;
          id_set  = 1'b1;
        end else begin
          idx_n = init_idx + IDX_W'(1);
        end
      end
      SET_ROW: if (byte_done) begin
        state_n = WR_CHARS;
        col_n   = '0;
        load    = 1'b1;
      end
      WR_CHARS: if (byte_done) begin
        load = 1'b1;
        if (col == COL_W'(NUM_COLS - 1)) begin
          state_n = SET_ROW;
          if (row == ROW_W'(NUM_ROWS - 1)) begin
            row_n = '0;
            fd_n  = 1'b1;
          end else begin
            row_n = row + ROW_W'(1);
          end
        end else begin
          col_n = col + COL_W'(1);
        end
      end
      default: state_n = PWR_WAIT;
    endcase

    case (2'(row_n))
      2'd0:    row_base = 8'h00;
      2'd1:    row_base = 8'h40;
      2'd2:    row_base = 8'(NUM_COLS);
      default: row_base = 8'(64 + NUM_COLS);
    endcase
    rd_idx = AW'(int'(row_n) * NUM_COLS + int'(col_n));

    case (state_n)
      INIT: begin
`ifdef LCD_4BIT_EN
        case (idx_n)
          3'd0, 3'd1, 3'd2: begin item_byte = 8'h30; item_single = 1'b1; end
          3'd3:             begin item_byte = 8'h20; item_single = 1'b1; end
          3'd4:             item_byte = 8'h28;
          3'd5:             item_byte = 8'h06;
          3'd6:             item_byte = 8'h0C;
          default:          item_byte = 8'h01;
        endcase
`else
        case (idx_n)
          2'd0:    item_byte = 8'h38;
          2'd1:    item_byte = 8'h06;
          2'd2:    item_byte = 8'h0C;
          default: item_byte = 8'h01;
        endcase
`endif
      end
      SET_ROW:  item_byte = 8'h80 | row_base;
      WR_CHARS: begin
        item_rs   = 1'b1;
        item_byte = fb[rd_idx];
      end
      default: item_byte = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PWR_WAIT;
      phase      <= PH_IDLE;
      cnt        <= '0;
      row        <= '0;
      col        <= '0;
      init_idx   <= '0;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      lcd_data   <= 8'h00;
      init_done  <= 1'b0;
      frame_done <= 1'b0;
`ifdef LCD_4BIT_EN
      byte_q     <= 8'h00;
      lo_nib     <= 1'b0;
      single     <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      row        <= row_n;
      col        <= col_n;
      init_idx   <= idx_n;
      frame_done <= fd_n;
      if (id_set) init_done <= 1'b1;
      if (load) begin
        phase  <= PH_SETUP;
        cnt    <= '0;
        lcd_en <= 1'b0;
        lcd_rs <= item_rs;
`ifdef LCD_4BIT_EN
        byte_q   <= item_byte;
        single   <= item_single;
        lo_nib   <= 1'b0;
        lcd_data <= {item_byte[7:4], 4'h0};
`else
        lcd_data <= item_byte;
`endif
      end else begin
        case (phase)
          PH_IDLE:  cnt <= (state == PWR_WAIT && state_n == PWR_WAIT) ? cnt + CNT_W'(1) : '0;
          PH_SETUP: if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            phase  <= PH_PULSE;
            cnt    <= '0;
            lcd_en <= 1'b1;
          end else cnt <= cnt + CNT_W'(1);
          PH_PULSE: if (cnt == CNT_W'(EN_HIGH_CYCLES - 1)) begin
            phase  <= PH_HOLD;
            cnt    <= '0;
            lcd_en <= 1'b0;
          end else cnt <= cnt + CNT_W'(1);
          default: if (hold_end) begin
            cnt <= '0;
`ifdef LCD_4BIT_EN
            if (first_half) begin
              phase    <= PH_SETUP;
              lo_nib   <= 1'b1;
              lcd_data <= {byte_q[3:0], 4'h0};
            end else phase <= PH_IDLE;
`else
            phase <= PH_IDLE;
`endif
          end else cnt <= cnt + CNT_W'(1);
        endcase
      end
    end
  end

  // Frame buffer: resets to spaces; out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fb[i] <= 8'h20;
    end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
      fb[wr_addr] <= wr_data;
    end
  end

endmodule
`default_nettype wire
